// File: rtl/multi_btn_press_counter.sv
// multi_btn_press_counter
//   NCH independent debounced push-button press counters.
//   Each raw button bit is brought into the clk domain by a 2-flop
//   synchroniser. A 4-state debounce FSM then qualifies both press and
//   release over DEB_CYC cycles. Every accepted press bumps a CW-bit count
//   and fires a one-cycle press_pulse.
//   Optional build macro: BTN_CNT_SATURATE_EN
//     undefined (default) : a press at the maximum count wraps to 0 and sets ovf
//     defined             : a press at the maximum count holds it there and sets ovf
//   ovf is sticky until the channel's clr bit or reset.
//   reset is synchronous and active-high.

module multi_btn_press_counter #(
  parameter int NCH     = 4,
  parameter int CW      = 8,
  parameter int DEB_CYC = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    btn,
  input  logic [NCH-1:0]    clr,
  output logic [NCH*CW-1:0] cnt_flat,
  output logic [NCH-1:0]    press_pulse,
  output logic [NCH-1:0]    ovf
);

  // Debounce counter sizing and the compare constants used by every channel
  localparam int              DW        = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0]   DCNT_LAST = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0]   DCNT_ONE  = DW'(1);
  localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HELD = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser shared by all channels
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] s1_q, s1_d;
  logic [NCH-1:0] s2_q, s2_d;

  // Next values of the synchroniser stages
  always_comb begin
    s1_d = btn;
    s2_d = s1_q;
  end

  // Synchroniser registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= {NCH{1'b0}};
      s2_q <= {NCH{1'b0}};
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSM and press counter
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t          state_q, state_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            pulse_q, pulse_d;
    logic            btn_s;
    logic            accept_s;

    assign btn_s = s2_q[g];

    // Debounce FSM: qualify press/release and flag the accepted press
    always_comb begin
      state_d  = state_q;
      dcnt_d   = dcnt_q;
      accept_s = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_s) begin
            state_d = ST_ARM;
            dcnt_d  = DCNT_ONE;
          end else begin
            dcnt_d  = {DW{1'b0}};
          end
        end
        ST_ARM: begin
          if (!btn_s) begin
            // Glitch shorter than the debounce window: drop it
            state_d = ST_IDLE;
            dcnt_d  = {DW{1'b0}};
          end else if (dcnt_q == DCNT_LAST) begin
            state_d  = ST_HELD;
            dcnt_d   = {DW{1'b0}};
            accept_s = 1'b1;
          end else begin
            dcnt_d  = dcnt_q + DCNT_ONE;
          end
        end
        ST_HELD: begin
          // A held button counts once; only a release moves us on
          if (!btn_s) begin
            state_d = ST_REL;
            dcnt_d  = DCNT_ONE;
          end else begin
            dcnt_d  = {DW{1'b0}};
          end
        end
        ST_REL: begin
          if (btn_s) begin
            // Bounce during release: still the same press
            state_d = ST_HELD;
            dcnt_d  = {DW{1'b0}};
          end else if (dcnt_q == DCNT_LAST) begin
            state_d = ST_IDLE;
            dcnt_d  = {DW{1'b0}};
          end else begin
            dcnt_d  = dcnt_q + DCNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          dcnt_d  = {DW{1'b0}};
        end
      endcase
    end

    // Count/overflow update; clr wins over the increment but not the pulse
    always_comb begin
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      pulse_d = accept_s;
      if (accept_s) begin
        if (clr[g]) begin
          cnt_d = {CW{1'b0}};
          ovf_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
`ifdef BTN_CNT_SATURATE_EN
          cnt_d = CNT_MAX;
`else
          cnt_d = {CW{1'b0}};
`endif
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (clr[g]) begin
        cnt_d = {CW{1'b0}};
        ovf_d = 1'b0;
      end else begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
      end
    end

    // Channel state registers; reset overrides clr and any press in flight
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        dcnt_q  <= {DW{1'b0}};
        cnt_q   <= {CW{1'b0}};
        ovf_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
        pulse_q <= pulse_d;
      end
    end

    assign cnt_flat[g*CW +: CW] = cnt_q;
    assign press_pulse[g]       = pulse_q;
    assign ovf[g]               = ovf_q;
  end

endmodule

// File: tb/tb_multi_btn_press_counter.sv
// Self-checking bench for multi_btn_press_counter (NCH=4, CW=4, DEB_CYC=4).
// Expected presses are queued when a button rise is driven. A negedge
// monitor pops them when press_pulse fires and checks channel, cycle,
// count and ovf.

module tb_multi_btn_press_counter;

  localparam int NCH     = 4;
  localparam int CW      = 4;
  localparam int DEB_CYC = 4;
  localparam int LAT     = DEB_CYC + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    btn;
  logic [NCH-1:0]    clr;
  logic [NCH*CW-1:0] cnt_flat;
  logic [NCH-1:0]    press_pulse;
  logic [NCH-1:0]    ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           ch;
    int           cyc;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  exp_t          sb_q[$];
  logic [CW-1:0] cnt_m [NCH];
  logic          ovf_m [NCH];

  multi_btn_press_counter #(
    .NCH     (NCH),
    .CW      (CW),
    .DEB_CYC (DEB_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .clr         (clr),
    .cnt_flat    (cnt_flat),
    .press_pulse (press_pulse),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the oldest queued press
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
        if (press_pulse[ch] === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse ch%0d cyc %0d: got pulse, required none", ch, cyc);
          end else begin
            e = sb_q.pop_front();
            if (e.ch !== ch || e.cyc !== cyc) begin
              errors++;
              $display("FAIL pulse_when: got ch%0d cyc %0d, required ch%0d cyc %0d", ch, cyc, e.ch, e.cyc);
            end
            checks++;
            if (cnt_flat[ch*CW +: CW] !== e.cnt || ovf[ch] !== e.ovf) begin
              errors++;
              $display("FAIL pulse_count ch%0d: got cnt %0d ovf %b, required cnt %0d ovf %b",
                       ch, cnt_flat[ch*CW +: CW], ovf[ch], e.cnt, e.ovf);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      cnt_m[i] = '0;
      ovf_m[i] = 1'b0;
    end
    sb_q.delete();
  endtask

  // Queue the outcome of a press whose rise is being driven right now
  task automatic push_press(input int ch, input logic with_clr);
    exp_t e;
    if (with_clr) begin
      cnt_m[ch] = '0;
      ovf_m[ch] = 1'b0;
    end else if (cnt_m[ch] == 4'hF) begin
`ifdef BTN_CNT_SATURATE_EN
      cnt_m[ch] = 4'hF;
`else
      cnt_m[ch] = 4'h0;
`endif
      ovf_m[ch] = 1'b1;
    end else begin
      cnt_m[ch] = cnt_m[ch] + 4'h1;
    end
    e.ch  = ch;
    e.cyc = cyc + LAT;
    e.cnt = cnt_m[ch];
    e.ovf = ovf_m[ch];
    sb_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d pending presses, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn   = '0;
    clr   = '0;
    tick(3);
    reset = 1'b0;
    model_clear();
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cnt_flat !== 16'h0000 || press_pulse !== 4'h0 || ovf !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: got cnt %h pulse %b ovf %b, required 0000 0000 0000",
               cnt_flat, press_pulse, ovf);
    end
  endtask

  task automatic test_single_press();
    push_press(0, 1'b0);
    btn[0] = 1'b1;
    tick(20);
    btn[0] = 1'b0;
    tick(10);
    check_drained("single_press");
    checks++;
    if (cnt_flat !== 16'h0001 || ovf !== 4'h0) begin
      errors++;
      $display("FAIL single_press_count: got cnt %h ovf %b, required 0001 0000", cnt_flat, ovf);
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 5; k++) begin
      btn[1] = 1'b1;
      tick(3);
      btn[1] = 1'b0;
      tick(3);
    end
    tick(6);
    checks++;
    if (cnt_flat[7:4] !== 4'h0) begin
      errors++;
      $display("FAIL glitch_count: got %0d, required 0", cnt_flat[7:4]);
    end
    push_press(1, 1'b0);
    btn[1] = 1'b1;
    tick(10);
    btn[1] = 1'b0;
    tick(10);
    check_drained("glitch");
    checks++;
    if (cnt_flat[7:4] !== 4'h1) begin
      errors++;
      $display("FAIL clean_after_glitch: got %0d, required 1", cnt_flat[7:4]);
    end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] exp_c;
`ifdef BTN_CNT_SATURATE_EN
    exp_c = 4'hF;
`else
    exp_c = 4'h1;
`endif
    for (int k = 0; k < 17; k++) begin
      push_press(2, 1'b0);
      btn[2] = 1'b1;
      tick(8);
      btn[2] = 1'b0;
      tick(8);
    end
    check_drained("overflow");
    checks++;
    if (cnt_flat[11:8] !== exp_c || ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: got cnt %0d ovf %b, required cnt %0d ovf 1",
               cnt_flat[11:8], ovf[2], exp_c);
    end
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    cnt_m[2] = '0;
    ovf_m[2] = 1'b0;
    tick(1);
    checks++;
    if (cnt_flat[11:8] !== 4'h0 || ovf[2] !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: got cnt %0d ovf %b, required cnt 0 ovf 0", cnt_flat[11:8], ovf[2]);
    end
  endtask

  task automatic test_clr_with_press();
    push_press(3, 1'b0);
    btn[3] = 1'b1;
    tick(10);
    btn[3] = 1'b0;
    tick(10);
    push_press(3, 1'b1);
    btn[3] = 1'b1;
    tick(LAT - 1);
    clr[3] = 1'b1;
    tick(1);
    clr[3] = 1'b0;
    tick(6);
    btn[3] = 1'b0;
    tick(10);
    check_drained("clr_with_press");
    checks++;
    if (cnt_flat[15:12] !== 4'h0 || ovf[3] !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_press_count: got cnt %0d ovf %b, required 0 0", cnt_flat[15:12], ovf[3]);
    end
  endtask

  task automatic test_reset_mid_arm();
    btn[0] = 1'b1;
    tick(4);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (press_pulse !== 4'h0 || cnt_flat !== 16'h0000) begin
        errors++;
        $display("FAIL reset_mid_arm_hold: got pulse %b cnt %h, required 0000 0000", press_pulse, cnt_flat);
      end
    end
    reset = 1'b0;
    model_clear();
    push_press(0, 1'b0);
    tick(8);
    btn[0] = 1'b0;
    tick(10);
    check_drained("reset_mid_arm");
    checks++;
    if (cnt_flat !== 16'h0001) begin
      errors++;
      $display("FAIL reset_mid_arm_count: got cnt %h, required 0001", cnt_flat);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int ch = 0; ch < NCH; ch++) push_press(ch, 1'b0);
    btn = 4'hF;
    tick(LAT);
    checks++;
    if (press_pulse !== 4'hF) begin
      errors++;
      $display("FAIL simultaneous_pulse: got %b, required 1111", press_pulse);
    end
    tick(4);
    btn = 4'h0;
    tick(10);
    check_drained("simultaneous");
    checks++;
    if (cnt_flat !== 16'h1111) begin
      errors++;
      $display("FAIL simultaneous_count: got %h, required 1111", cnt_flat);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn   = '0;
    clr   = '0;
    model_clear();
    test_reset();
    test_single_press();
    test_glitch();
    test_overflow();
    test_clr_with_press();
    test_reset_mid_arm();
    test_simultaneous();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
